pdp8_bus_arbiter: RTL and testbench

- Sequences the shared nibble-serial external memory/IO bus.
- Arbitrates that bus between two word-level requesters: port 0 is the CPU, port 1 is the front-panel loader/DMA engine.
- Serialises each granted 12-bit transaction into address, optional IO-intro, and data beats, and reassembles 12-bit read data from the 4-bit input.
- Sits between the requesters and the external latch/SRAM/IO pins.

---
 rtl/pdp8_bus_if.sv | 33 +++
 rtl/pdp8_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_pdp8_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdp8_bus_if.sv
// rtl/pdp8_bus_if.sv - requester handshake and external nibble-bus signals for pdp8_bus_arbiter
interface pdp8_bus_if;
  logic        req0;
  logic        req1;
  logic        write0;
  logic        write1;
  logic        io0;
  logic        io1;
  logic [11:0] addr0;
  logic [11:0] addr1;
  logic [11:0] wdata0;
  logic [11:0] wdata1;
  logic        done0;
  logic        done1;
  logic [11:0] rdata;
  logic        io_ready;
  logic [7:0]  bus_out;
  logic [3:0]  bus_in;
  logic        busy;
  logic        grant;

  // Arbiter side.
  modport slave (
    input  req0, req1, write0, write1, io0, io1, addr0, addr1, wdata0, wdata1, bus_in,
    output done0, done1, rdata, io_ready, bus_out, busy, grant
  );

  // Requester / pin side.
  modport master (
    output req0, req1, write0, write1, io0, io1, addr0, addr1, wdata0, wdata1, bus_in,
    input  done0, done1, rdata, io_ready, bus_out, busy, grant
  );
endinterface

// File: rtl/pdp8_bus_arbiter.sv
// rtl/pdp8_bus_arbiter.sv - two-port arbiter and beat sequencer for the nibble-serial PDP-8 memory/IO bus
module pdp8_bus_arbiter #(
  parameter bit         FIXED_PRIO = 1'b0,
  parameter logic [7:0] IDLE_BUS   = 8'h00
) (
  input  logic      clk,
  input  logic      reset_n,
  pdp8_bus_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_AH, S_AL, S_IOI, S_DH, S_DM, S_DL} state_t;

  state_t      state_q;
  logic [11:0] addr_q;
  logic [11:0] wdata_q;
  logic [11:0] rdata_q;
  logic [7:0]  rd_q;
  logic [7:0]  bus_out_q;
  logic        write_q;
  logic        io_q;
  logic        grant_q;
  logic        prio_q;
  logic        ior_q;
  logic        io_ready_q;
  logic        done0_q;
  logic        done1_q;
  logic        busy_q;

  logic        req_v0;
  logic        req_v1;
  logic        start;
  logic        win_d;
  logic [11:0] w_addr;
  logic [11:0] w_wdata;
  logic        w_write;
  logic        w_io;
  logic [3:0]  nib_h;
  logic [3:0]  nib_m;
  logic [3:0]  nib_l;

  // The finishing port is masked in its DL cycle so a held req is not mistaken for a new one.
  always_comb begin
    req_v0  = bus.req0 && !(state_q == S_DL && !grant_q);
    req_v1  = bus.req1 && !(state_q == S_DL &&  grant_q);
    start   = (state_q == S_IDLE || state_q == S_DL) && (req_v0 || req_v1);
    if (req_v0 && req_v1) win_d = FIXED_PRIO ? 1'b0 : prio_q;
    else                  win_d = req_v1;
    w_addr  = win_d ? bus.addr1  : bus.addr0;
    w_wdata = win_d ? bus.wdata1 : bus.wdata0;
    w_write = win_d ? bus.write1 : bus.write0;
    w_io    = win_d ? bus.io1    : bus.io0;
  end

  assign nib_h = write_q ? wdata_q[11:8] : 4'h0;
  assign nib_m = write_q ? wdata_q[7:4]  : 4'h0;
  assign nib_l = write_q ? wdata_q[3:0]  : 4'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 12'h000;
      wdata_q    <= 12'h000;
      rdata_q    <= 12'h000;
      rd_q       <= 8'h00;
      bus_out_q  <= IDLE_BUS;
      write_q    <= 1'b0;
      io_q       <= 1'b0;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      ior_q      <= 1'b0;
      io_ready_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (start) begin
        addr_q  <= w_addr;
        wdata_q <= w_wdata;
        write_q <= w_write;
        io_q    <= w_io;
        grant_q <= win_d;
        prio_q  <= ~win_d;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_AH;
            bus_out_q <= {2'b10, w_addr[11:6]};
            busy_q    <= 1'b1;
          end
        end
        S_AH: begin
          state_q   <= S_AL;
          bus_out_q <= {2'b11, addr_q[5:0]};
        end
        S_AL: begin
          if (io_q) begin
            state_q   <= S_IOI;
            bus_out_q <= {3'b011, write_q, 4'h0};
          end else begin
            state_q   <= S_DH;
            bus_out_q <= {3'b000, write_q, nib_h};
          end
        end
        S_IOI: begin
          ior_q     <= bus.bus_in[0];
          state_q   <= S_DH;
          bus_out_q <= {3'b000, write_q, nib_h};
        end
        S_DH: begin
          rd_q[7:4] <= bus.bus_in;
          state_q   <= S_DM;
          bus_out_q <= {3'b001, write_q, nib_m};
        end
        S_DM: begin
          rd_q[3:0] <= bus.bus_in;
          state_q   <= S_DL;
          bus_out_q <= {3'b010, write_q, nib_l};
        end
        S_DL: begin
          done0_q    <= ~grant_q;
          done1_q    <= grant_q;
          io_ready_q <= io_q & ior_q;
          if (!write_q) rdata_q <= {rd_q, bus.bus_in};
          if (start) begin
            state_q   <= S_AH;
            bus_out_q <= {2'b10, w_addr[11:6]};
          end else begin
            state_q   <= S_IDLE;
            bus_out_q <= IDLE_BUS;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          bus_out_q <= IDLE_BUS;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.rdata    = rdata_q;
  assign bus.io_ready = io_ready_q;
  assign bus.bus_out  = bus_out_q;
  assign bus.busy     = busy_q;
  assign bus.grant    = grant_q;

endmodule

// File: tb/tb_pdp8_bus_arbiter.sv
// tb/tb_pdp8_bus_arbiter.sv - scoreboard bench for pdp8_bus_arbiter (round-robin and fixed-priority instances)
module tb_pdp8_bus_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pdp8_bus_if a();
  pdp8_bus_if b();

  pdp8_bus_arbiter #(.FIXED_PRIO(1'b0), .IDLE_BUS(8'h00)) dut_rr (.clk(clk), .reset_n(reset_n), .bus(a));
  pdp8_bus_arbiter #(.FIXED_PRIO(1'b1), .IDLE_BUS(8'h00)) dut_fp (.clk(clk), .reset_n(reset_n), .bus(b));

  typedef struct {
    bit          port;
    logic [11:0] rdata;
    bit          rdy;
  } done_t;

  logic [7:0]  exp_beat_q[$];
  done_t       exp_done_q[$];
  logic [11:0] model_rdata;
  logic [7:0]  eb;
  done_t       ed;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [3:0]  dev_h, dev_m, dev_l;
  logic        dev_rdy;

  always @(posedge clk) cyc <= cyc + 1;

  // Device model: answers data beats with the programmed nibbles, IO-intro with the ready bit.
  always @(negedge clk) begin
    if (a.busy && a.bus_out[7:5] == 3'b000)      a.bus_in = dev_h;
    else if (a.busy && a.bus_out[7:5] == 3'b001) a.bus_in = dev_m;
    else if (a.busy && a.bus_out[7:5] == 3'b010) a.bus_in = dev_l;
    else if (a.busy && a.bus_out[7:5] == 3'b011) a.bus_in = {3'b000, dev_rdy};
    else                                         a.bus_in = 4'h0;
  end

  // Scoreboard: every busy beat and every done pulse is matched against the expectation queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (a.busy) begin
        checks++;
        if (exp_beat_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra: got %h, required no beat", a.bus_out);
        end else begin
          eb = exp_beat_q.pop_front();
          if (a.bus_out !== eb) begin
            errors++;
            $display("FAIL beat: got %h, required %h (cycle %0d)", a.bus_out, eb, cyc);
          end
        end
      end
      if (a.done0 || a.done1) begin
        checks++;
        if (a.done0 && a.done1) begin
          errors++;
          $display("FAIL done_both: done0=%b done1=%b, required one-hot", a.done0, a.done1);
        end
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL done_extra: done0=%b done1=%b, required no done", a.done0, a.done1);
        end else begin
          ed = exp_done_q.pop_front();
          if (a.done1 !== ed.port) begin
            errors++;
            $display("FAIL done_port: got port %b, required %b", a.done1, ed.port);
          end
          checks++;
          if (a.rdata !== ed.rdata) begin
            errors++;
            $display("FAIL done_rdata: got %h, required %h", a.rdata, ed.rdata);
          end
          checks++;
          if (a.io_ready !== ed.rdy) begin
            errors++;
            $display("FAIL done_io_ready: got %b, required %b", a.io_ready, ed.rdy);
          end
        end
      end
    end
  end

  task automatic push_txn(input bit p, input bit w, input bit io, input logic [11:0] ad, input logic [11:0] wd);
    done_t d;
    exp_beat_q.push_back({2'b10, ad[11:6]});
    exp_beat_q.push_back({2'b11, ad[5:0]});
    if (io) exp_beat_q.push_back({3'b011, w, 4'h0});
    exp_beat_q.push_back({3'b000, w, w ? wd[11:8] : 4'h0});
    exp_beat_q.push_back({3'b001, w, w ? wd[7:4]  : 4'h0});
    exp_beat_q.push_back({3'b010, w, w ? wd[3:0]  : 4'h0});
    if (!w) model_rdata = {dev_h, dev_m, dev_l};
    d.port  = p;
    d.rdata = model_rdata;
    d.rdy   = io & dev_rdy;
    exp_done_q.push_back(d);
  endtask

  task automatic set_port(input bit p, input bit w, input bit io, input logic [11:0] ad, input logic [11:0] wd);
    if (p) begin
      a.write1 = w; a.io1 = io; a.addr1 = ad; a.wdata1 = wd; a.req1 = 1'b1;
    end else begin
      a.write0 = w; a.io0 = io; a.addr0 = ad; a.wdata0 = wd; a.req0 = 1'b1;
    end
  endtask

  task automatic wait_done(input bit p, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      if (p ? a.done1 : a.done0) begin
        got = 1'b1;
        if (p) a.req1 = 1'b0; else a.req0 = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a.bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus_out: got %h, required 00", a.bus_out); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", a.busy); end
    checks++; if ({a.done0, a.done1} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b, required 00", {a.done0, a.done1}); end
    checks++; if (a.io_ready !== 1'b0) begin errors++; $display("FAIL reset_io_ready: got %b, required 0", a.io_ready); end
    checks++; if (a.grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b, required 0", a.grant); end
    checks++; if (a.rdata !== 12'h000) begin errors++; $display("FAIL reset_rdata: got %h, required 000", a.rdata); end
    checks++; if (b.bus_out !== 8'h00) begin errors++; $display("FAIL reset_fp_bus_out: got %h, required 00", b.bus_out); end
    reset_n = 1'b1;
  endtask

  task automatic test_mem_read;
    bit got; int t0; int extra;
    dev_h = 4'h5; dev_m = 4'hA; dev_l = 4'h3; dev_rdy = 1'b0;
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, 12'o1234, 12'h000);
    push_txn(1'b0, 1'b0, 1'b0, 12'o1234, 12'h000);
    t0 = cyc;
    wait_done(1'b0, got);
    checks++;
    if (!got) begin errors++; $display("FAIL mem_read_timeout: no done0, required done0"); end
    else begin
      checks++; if (cyc - t0 !== 6) begin errors++; $display("FAIL mem_read_latency: got %0d, required 6", cyc - t0); end
      checks++; if (a.rdata !== 12'h5A3) begin errors++; $display("FAIL mem_read_rdata: got %h, required 5a3", a.rdata); end
      checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b, required 0", a.busy); end
    end
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (a.done0 || a.done1 || a.busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL single_no_regrant: got %0d active cycles, required 0", extra); end
  endtask

  task automatic test_mem_write;
    bit got; int t0;
    @(posedge clk); #1;
    set_port(1'b1, 1'b1, 1'b0, 12'hFFF, 12'hABC);
    push_txn(1'b1, 1'b1, 1'b0, 12'hFFF, 12'hABC);
    t0 = cyc;
    wait_done(1'b1, got);
    checks++;
    if (!got) begin errors++; $display("FAIL mem_write_timeout: no done1, required done1"); end
    else begin
      checks++; if (cyc - t0 !== 6) begin errors++; $display("FAIL mem_write_latency: got %0d, required 6", cyc - t0); end
      checks++; if (a.rdata !== 12'h5A3) begin errors++; $display("FAIL mem_write_rdata_hold: got %h, required 5a3", a.rdata); end
      checks++; if (a.grant !== 1'b1) begin errors++; $display("FAIL mem_write_grant: got %b, required 1", a.grant); end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_io_read;
    bit got; int t0;
    for (int k = 0; k < 2; k++) begin
      dev_rdy = (k == 0);
      dev_h = (k == 0) ? 4'h1 : 4'h7;
      dev_m = (k == 0) ? 4'h2 : 4'h8;
      dev_l = (k == 0) ? 4'h3 : 4'h9;
      @(posedge clk); #1;
      set_port(1'b0, 1'b0, 1'b1, 12'o0040, 12'h000);
      push_txn(1'b0, 1'b0, 1'b1, 12'o0040, 12'h000);
      t0 = cyc;
      wait_done(1'b0, got);
      checks++;
      if (!got) begin errors++; $display("FAIL io_read_timeout[%0d]: no done0, required done0", k); end
      else begin
        checks++; if (cyc - t0 !== 7) begin errors++; $display("FAIL io_read_latency[%0d]: got %0d, required 7", k, cyc - t0); end
        checks++; if (a.io_ready !== (k == 0)) begin errors++; $display("FAIL io_ready[%0d]: got %b, required %b", k, a.io_ready, (k == 0)); end
      end
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int n; int dc[4];
    dev_h = 4'h4; dev_m = 4'hB; dev_l = 4'h6; dev_rdy = 1'b0;
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, 12'h111, 12'h000);
    set_port(1'b1, 1'b1, 1'b0, 12'h222, 12'h345);
    // Last grant was port 0, so port 1 goes first and the two alternate.
    push_txn(1'b1, 1'b1, 1'b0, 12'h222, 12'h345);
    push_txn(1'b0, 1'b0, 1'b0, 12'h111, 12'h000);
    push_txn(1'b1, 1'b1, 1'b0, 12'h222, 12'h345);
    push_txn(1'b0, 1'b0, 1'b0, 12'h111, 12'h000);
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(posedge clk); #1;
      if (a.done0 || a.done1) begin
        dc[n] = cyc;
        n++;
        if (n == 3) begin a.req0 = 1'b0; a.req1 = 1'b0; end
      end
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d dones, required 4", n); end
    else begin
      for (int j = 1; j < 4; j++) begin
        checks++;
        if (dc[j] - dc[j-1] !== 5) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d, required 5", j, dc[j] - dc[j-1]); end
      end
      checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: busy=%b, required 0", a.busy); end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_abort;
    bit seen; bit got; int extra; int t0;
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 12'h0F0, 12'h9C3);
    push_txn(1'b0, 1'b1, 1'b0, 12'h0F0, 12'h9C3);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (a.busy && a.bus_out[7:5] == 3'b001) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_dm_timeout: DM beat not seen, required DM"); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (a.bus_out !== 8'h00) begin errors++; $display("FAIL abort_bus_out: got %h, required 00", a.bus_out); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", a.busy); end
    a.req0 = 1'b0;
    exp_beat_q.delete();
    exp_done_q.delete();
    model_rdata = 12'h000;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (a.done0 || a.done1 || a.busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles, required 0", extra); end
    dev_h = 4'hC; dev_m = 4'h0; dev_l = 4'hE;
    set_port(1'b1, 1'b0, 1'b0, 12'h555, 12'h000);
    push_txn(1'b1, 1'b0, 1'b0, 12'h555, 12'h000);
    t0 = cyc;
    wait_done(1'b1, got);
    checks++;
    if (!got) begin errors++; $display("FAIL abort_restart_timeout: no done1, required done1"); end
    else begin
      checks++; if (cyc - t0 !== 6) begin errors++; $display("FAIL abort_restart_latency: got %0d, required 6", cyc - t0); end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_fixed_prio;
    bit got; int first; int second;
    @(posedge clk); #1;
    b.addr0 = 12'h010; b.write0 = 1'b0; b.io0 = 1'b0; b.req0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      if (b.done0) begin got = 1'b1; b.req0 = 1'b0; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL fp_first_timeout: no done0, required done0"); end
    @(posedge clk); #1;
    // Port 0 was granted last; fixed priority must still pick it over port 1.
    b.addr1 = 12'h020; b.write1 = 1'b1; b.io1 = 1'b0; b.wdata1 = 12'h777;
    b.req0 = 1'b1; b.req1 = 1'b1;
    first = -1; second = -1;
    for (int i = 0; i < 40 && second < 0; i++) begin
      @(posedge clk); #1;
      if (b.done0) begin if (first < 0) first = 0; else second = 0; b.req0 = 1'b0; end
      if (b.done1) begin if (first < 0) first = 1; else second = 1; b.req1 = 1'b0; end
    end
    checks++; if (first !== 0) begin errors++; $display("FAIL fp_first_grant: got %0d, required 0", first); end
    checks++; if (second !== 1) begin errors++; $display("FAIL fp_second_grant: got %0d, required 1", second); end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    {a.req0, a.req1, a.write0, a.write1, a.io0, a.io1} = 6'b0;
    a.addr0 = 12'h000; a.addr1 = 12'h000; a.wdata0 = 12'h000; a.wdata1 = 12'h000;
    {b.req0, b.req1, b.write0, b.write1, b.io0, b.io1} = 6'b0;
    b.addr0 = 12'h000; b.addr1 = 12'h000; b.wdata0 = 12'h000; b.wdata1 = 12'h000;
    b.bus_in = 4'h0;
    dev_h = 4'h0; dev_m = 4'h0; dev_l = 4'h0; dev_rdy = 1'b0;
    model_rdata = 12'h000;
    test_reset();
    test_mem_read();
    test_mem_write();
    test_io_read();
    test_back_to_back();
    test_reset_abort();
    test_fixed_prio();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_beat_q.size() != 0) begin errors++; $display("FAIL beats_left: got %0d unmatched, required 0", exp_beat_q.size()); end
    checks++;
    if (exp_done_q.size() != 0) begin errors++; $display("FAIL dones_left: got %0d unmatched, required 0", exp_done_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
